// File: rtl/router_output_arbiter_if.sv
// Request/grant bundle between the router inputs and one output-port arbiter.
// Carries timeout_err only when ARB_WATCHDOG_EN is defined.
interface router_output_arbiter_if #(
  parameter int unsigned N_PORTS = 5
);
  localparam int unsigned IDX_W = $clog2(N_PORTS);

  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] tail;
  logic               out_ready;
  logic [N_PORTS-1:0] grant;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic               xfer;
`ifdef ARB_WATCHDOG_EN
  logic               timeout_err;
`endif

  modport master (
    output req,
    output tail,
    output out_ready,
    input  grant,
    input  grant_valid,
    input  grant_idx,
`ifdef ARB_WATCHDOG_EN
    input  timeout_err,
`endif
    input  xfer
  );

  modport slave (
    input  req,
    input  tail,
    input  out_ready,
    output grant,
    output grant_valid,
    output grant_idx,
`ifdef ARB_WATCHDOG_EN
    output timeout_err,
`endif
    output xfer
  );
endinterface

// File: rtl/router_output_arbiter.sv
// Round-robin, packet-locking arbiter for one router output port.
// Optional stall watchdog is built when ARB_WATCHDOG_EN is defined.
module router_output_arbiter #(
  parameter int unsigned N_PORTS = 5
`ifdef ARB_WATCHDOG_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input logic                     clk,
  input logic                     reset,
  router_output_arbiter_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(N_PORTS);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e             state_q;
  logic [N_PORTS-1:0] grant_q;
  logic               grant_valid_q;
  logic [IDX_W-1:0]   grant_idx_q;
  logic [IDX_W-1:0]   rr_ptr_q;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  int unsigned        cand;
  logic [IDX_W-1:0]   next_ptr;
  logic               xfer;
  logic               owner_tail;

  // First requester at or above rr_ptr, wrapping modulo N_PORTS.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < int'(N_PORTS); k++) begin
      cand = (int'(rr_ptr_q) + k) % N_PORTS;
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    xfer       = grant_valid_q & bus.req[grant_idx_q] & bus.out_ready;
    owner_tail = bus.tail[grant_idx_q];
    next_ptr   = (grant_idx_q == IDX_W'(N_PORTS - 1)) ? '0 : grant_idx_q + 1'b1;
  end

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CntLimit = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] stall_cnt_q;
  logic             timeout_err_q;
  logic             stall_hit;

  assign stall_hit = (state_q == StLocked) && !xfer && (stall_cnt_q == CntLimit);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      rr_ptr_q      <= '0;
`ifdef ARB_WATCHDOG_EN
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            state_q       <= StLocked;
            grant_q       <= {{(N_PORTS - 1){1'b0}}, 1'b1} << pick_idx;
            grant_valid_q <= 1'b1;
            grant_idx_q   <= pick_idx;
          end
        end
        StLocked: begin
`ifdef ARB_WATCHDOG_EN
          if ((xfer && owner_tail) || stall_hit) begin
            timeout_err_q <= timeout_err_q | stall_hit;
`else
          if (xfer && owner_tail) begin
`endif
            state_q       <= StIdle;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            rr_ptr_q      <= next_ptr;
          end
        end
      endcase
`ifdef ARB_WATCHDOG_EN
      // Counter only runs while locked so each new owner starts with a full budget.
      if (state_q != StLocked || xfer) begin
        stall_cnt_q <= '0;
      end else if (stall_cnt_q != CntLimit) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.xfer        = xfer;
`ifdef ARB_WATCHDOG_EN
  assign bus.timeout_err = timeout_err_q;
`endif
endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter; watchdog steps follow ARB_WATCHDOG_EN.
module tb_router_output_arbiter;
  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   xfer_cnt;

  router_output_arbiter_if #(.N_PORTS(5)) bus ();

`ifdef ARB_WATCHDOG_EN
  router_output_arbiter #(.N_PORTS(5), .TIMEOUT_CYCLES(8)) dut (
`else
  router_output_arbiter #(.N_PORTS(5)) dut (
`endif
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic rdy);
    bus.req       = r;
    bus.tail      = t;
    bus.out_ready = rdy;
    #1;
  endtask

  task automatic chk_owner(input string tag, input logic [4:0] g, input logic [2:0] idx,
                           input logic x);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".idx"}, 32'(bus.grant_idx), 32'(idx));
    chk({tag, ".valid"}, 32'(bus.grant_valid), 32'(|g));
    chk({tag, ".xfer"}, 32'(bus.xfer), 32'(x));
  endtask

  initial begin
    logic [2:0] rr_order [6];
    errors   = 0;
    checks   = 0;
    xfer_cnt = 0;
    rr_order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    // 1: reset holds everything idle despite full requests
    reset = 1'b1;
    drive(5'b11111, 5'b00000, 1'b1);
    edge_step();
    edge_step();
    chk_owner("rst", 5'b00000, 3'd0, 1'b0);
    reset = 1'b0;
    edge_step();
    chk_owner("rst_rel", 5'b00001, 3'd0, 1'b1);
    drive(5'b11111, 5'b00001, 1'b1);
    edge_step();
    drive(5'b00000, 5'b00000, 1'b1);
    chk_owner("bubble1", 5'b00000, 3'd0, 1'b0);
    edge_step();

    // 2: N and C alternate 3-flit packets; rr_ptr=1 so N wins first
    drive(5'b10100, 5'b00000, 1'b1);
    edge_step();
    chk_owner("n_f1", 5'b00100, 3'd2, 1'b1);
    edge_step();
    chk_owner("n_f2", 5'b00100, 3'd2, 1'b1);
    edge_step();
    drive(5'b10100, 5'b00100, 1'b1);
    chk_owner("n_f3", 5'b00100, 3'd2, 1'b1);
    edge_step();
    drive(5'b10100, 5'b00000, 1'b1);
    chk_owner("n_bub", 5'b00000, 3'd0, 1'b0);
    edge_step();
    chk_owner("c_f1", 5'b10000, 3'd4, 1'b1);
    edge_step();
    chk_owner("c_f2", 5'b10000, 3'd4, 1'b1);
    edge_step();
    drive(5'b10100, 5'b10000, 1'b1);
    chk_owner("c_f3", 5'b10000, 3'd4, 1'b1);
    edge_step();
    drive(5'b10100, 5'b00000, 1'b1);
    chk_owner("c_bub", 5'b00000, 3'd0, 1'b0);
    edge_step();
    chk_owner("n_again", 5'b00100, 3'd2, 1'b1);
    edge_step();

    // 3: N keeps the lock across backpressure; S request and S tail ignored
    drive(5'b10101, 5'b00001, 1'b0);
    chk_owner("bp0", 5'b00100, 3'd2, 1'b0);
    edge_step();
    chk_owner("bp1", 5'b00100, 3'd2, 1'b0);
    edge_step();
    drive(5'b10101, 5'b00101, 1'b1);
    chk_owner("bp_tail", 5'b00100, 3'd2, 1'b1);
    edge_step();
    drive(5'b10101, 5'b00000, 1'b1);
    chk_owner("bp_bub", 5'b00000, 3'd0, 1'b0);
    edge_step();
    // rr_ptr=3 after N, so C beats the waiting S
    drive(5'b10101, 5'b10000, 1'b1);
    chk_owner("c_single", 5'b10000, 3'd4, 1'b1);
    edge_step();

    // 4: move rr_ptr to 4 via a single-flit E packet, then check wrap to S, then W
    drive(5'b01000, 5'b01000, 1'b1);
    chk_owner("c_bub2", 5'b00000, 3'd0, 1'b0);
    edge_step();
    chk_owner("e_single", 5'b01000, 3'd3, 1'b1);
    edge_step();
    drive(5'b00011, 5'b00000, 1'b1);
    chk_owner("e_bub", 5'b00000, 3'd0, 1'b0);
    edge_step();
    drive(5'b00011, 5'b00001, 1'b1);
    chk_owner("wrap_s", 5'b00001, 3'd0, 1'b1);
    edge_step();
    drive(5'b00011, 5'b00000, 1'b1);
    chk_owner("s_bub", 5'b00000, 3'd0, 1'b0);
    edge_step();
    chk_owner("then_w", 5'b00010, 3'd1, 1'b1);

    // reset mid-packet drops W's lock and rr_ptr
    reset = 1'b1;
    edge_step();
    reset = 1'b0;
    drive(5'b11111, 5'b11111, 1'b1);
    chk_owner("rst_mid", 5'b00000, 3'd0, 1'b0);
    edge_step();

    // 5: everyone sends 1-flit packets; strict rotation with one bubble each
    for (int p = 0; p < 6; p++) begin
      chk($sformatf("rr%0d.grant", p), 32'(bus.grant), 32'(5'b00001 << rr_order[p]));
      chk($sformatf("rr%0d.idx", p), 32'(bus.grant_idx), 32'(rr_order[p]));
      if (bus.xfer) xfer_cnt++;
      edge_step();
      if (bus.xfer) xfer_cnt++;
      chk($sformatf("rr%0d.bubble", p), 32'(bus.grant), 32'd0);
      if (p == 5) drive(5'b00000, 5'b00000, 1'b1);
      edge_step();
    end
    chk("rr.xfer_count", 32'(xfer_cnt), 32'd6);

    // 6: W (rr_ptr=1) sends one flit then drops req mid-packet
    drive(5'b00010, 5'b00000, 1'b1);
    edge_step();
    chk_owner("w_f1", 5'b00010, 3'd1, 1'b1);
    edge_step();
    drive(5'b00000, 5'b00000, 1'b1);
`ifdef ARB_WATCHDOG_EN
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("wd_hold%0d", c), 32'(bus.grant), 32'(5'b00010));
      chk($sformatf("wd_err%0d", c), 32'(bus.timeout_err), 32'd0);
      edge_step();
    end
    drive(5'b00101, 5'b00000, 1'b1);
    chk_owner("wd_drop", 5'b00000, 3'd0, 1'b0);
    chk("wd_err_set", 32'(bus.timeout_err), 32'd1);
    edge_step();
    chk_owner("wd_next", 5'b00100, 3'd2, 1'b1);
    chk("wd_err_sticky", 32'(bus.timeout_err), 32'd1);
`else
    for (int c = 0; c < 110; c++) begin
      chk($sformatf("hold%0d", c), 32'(bus.grant), 32'(5'b00010));
      edge_step();
    end
    drive(5'b00010, 5'b00010, 1'b1);
    chk_owner("hold_tail", 5'b00010, 3'd1, 1'b1);
    edge_step();
    drive(5'b00101, 5'b00000, 1'b1);
    chk_owner("hold_bub", 5'b00000, 3'd0, 1'b0);
    edge_step();
    chk_owner("hold_next", 5'b00100, 3'd2, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
